// File: rtl/piece_move_animator.sv
// Slides one chess piece from a source square to a destination square, one bounded step per
// video frame, and reports landing and capture events to the board and sprite logic.
module piece_move_animator #(
  parameter int unsigned SQUARE = 60,
  parameter int unsigned STEP   = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [4:0] piece_id,
  input  logic [2:0] from_col,
  input  logic [2:0] from_row,
  input  logic [2:0] to_col,
  input  logic [2:0] to_row,
  input  logic       capture,
  input  logic [4:0] victim_id,
  input  logic       cancel,
  output logic       anim_active,
  output logic [4:0] anim_piece,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic       done,
  output logic       capture_pulse,
  output logic [4:0] capture_id
);

  typedef enum logic [1:0] {StIdle, StMove, StLand} state_e;

  localparam logic [10:0] StepW = 11'(STEP);

  function automatic logic [9:0] sq_off(input logic [2:0] idx);
    return 10'(idx) * 10'(SQUARE);
  endfunction

  // Moves cur toward tgt by at most StepW, never past it.
  function automatic logic [9:0] step_axis(input logic [9:0] cur, input logic [9:0] tgt);
    logic signed [10:0] diff;
    logic [10:0]        mag;
    logic [10:0]        stp;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[10] ? $unsigned(-diff) : $unsigned(diff);
    stp  = (mag < StepW) ? mag : StepW;
    return diff[10] ? (cur - stp[9:0]) : (cur + stp[9:0]);
  endfunction

  state_e     r_state, w_state;
  logic [4:0] r_piece, w_piece;
  logic [4:0] r_victim, w_victim;
  logic       r_capture, w_capture;
  logic [9:0] r_cur_x, w_cur_x;
  logic [9:0] r_cur_y, w_cur_y;
  logic [9:0] r_tgt_x, w_tgt_x;
  logic [9:0] r_tgt_y, w_tgt_y;
  logic [9:0] r_src_x, w_src_x;
  logic [9:0] r_src_y, w_src_y;
  logic [9:0] w_step_x, w_step_y;

  assign w_step_x = step_axis(r_cur_x, r_tgt_x);
  assign w_step_y = step_axis(r_cur_y, r_tgt_y);

  always_comb begin
    w_state   = r_state;
    w_piece   = r_piece;
    w_victim  = r_victim;
    w_capture = r_capture;
    w_cur_x   = r_cur_x;
    w_cur_y   = r_cur_y;
    w_tgt_x   = r_tgt_x;
    w_tgt_y   = r_tgt_y;
    w_src_x   = r_src_x;
    w_src_y   = r_src_y;
    unique case (r_state)
      StIdle: begin
        if (move_valid) begin
          w_piece   = piece_id;
          w_victim  = victim_id;
          w_capture = capture;
          w_cur_x   = sq_off(from_col);
          w_cur_y   = sq_off(from_row);
          w_src_x   = sq_off(from_col);
          w_src_y   = sq_off(from_row);
          w_tgt_x   = sq_off(to_col);
          w_tgt_y   = sq_off(to_row);
          w_state   = StMove;
        end
      end
      StMove: begin
        // Cancel wins over a coincident frame pulse.
        if (cancel) begin
          w_cur_x = r_src_x;
          w_cur_y = r_src_y;
          w_state = StIdle;
        end else if (frame_start) begin
          w_cur_x = w_step_x;
          w_cur_y = w_step_y;
          if ((w_step_x == r_tgt_x) && (w_step_y == r_tgt_y)) w_state = StLand;
        end
      end
      StLand:  w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_piece   <= '0;
      r_victim  <= '0;
      r_capture <= 1'b0;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_tgt_x   <= '0;
      r_tgt_y   <= '0;
      r_src_x   <= '0;
      r_src_y   <= '0;
    end else begin
      r_state   <= w_state;
      r_piece   <= w_piece;
      r_victim  <= w_victim;
      r_capture <= w_capture;
      r_cur_x   <= w_cur_x;
      r_cur_y   <= w_cur_y;
      r_tgt_x   <= w_tgt_x;
      r_tgt_y   <= w_tgt_y;
      r_src_x   <= w_src_x;
      r_src_y   <= w_src_y;
    end
  end

  assign move_ready    = (r_state == StIdle);
  assign anim_active   = (r_state != StIdle);
  assign done          = (r_state == StLand);
  assign capture_pulse = (r_state == StLand) && r_capture;
  assign anim_piece    = r_piece;
  assign capture_id    = r_victim;
  assign offsetX       = r_cur_x;
  assign offsetY       = r_cur_y;

endmodule

// File: tb/tb_piece_move_animator.sv
// Directed bench for piece_move_animator: a STEP=4 instance for most moves and a STEP=7
// instance for the non-divisible step case.
module tb_piece_move_animator;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_valid7 = 1'b0;
  logic [4:0] piece_id = '0;
  logic [2:0] from_col = '0, from_row = '0, to_col = '0, to_row = '0;
  logic       capture = 1'b0;
  logic [4:0] victim_id = '0;
  logic       cancel = 1'b0;

  logic       move_ready, anim_active, done, capture_pulse;
  logic [4:0] anim_piece, capture_id;
  logic [9:0] offsetX, offsetY;
  logic       move_ready7, anim_active7, done7, capture_pulse7;
  logic [4:0] anim_piece7, capture_id7;
  logic [9:0] offsetX7, offsetY7;

  int n_checks = 0;
  int n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  piece_move_animator #(.SQUARE(60), .STEP(4)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
    .move_valid(move_valid), .move_ready(move_ready), .piece_id(piece_id),
    .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row),
    .capture(capture), .victim_id(victim_id), .cancel(cancel),
    .anim_active(anim_active), .anim_piece(anim_piece), .offsetX(offsetX), .offsetY(offsetY),
    .done(done), .capture_pulse(capture_pulse), .capture_id(capture_id)
  );

  piece_move_animator #(.SQUARE(60), .STEP(7)) dut7 (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
    .move_valid(move_valid7), .move_ready(move_ready7), .piece_id(piece_id),
    .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row),
    .capture(capture), .victim_id(victim_id), .cancel(cancel),
    .anim_active(anim_active7), .anim_piece(anim_piece7), .offsetX(offsetX7),
    .offsetY(offsetY7), .done(done7), .capture_pulse(capture_pulse7), .capture_id(capture_id7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame();
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic setup(input logic [4:0] pid, input logic [2:0] fc, input logic [2:0] fr,
                       input logic [2:0] tc, input logic [2:0] tr, input logic cap,
                       input logic [4:0] vid);
    piece_id  = pid;
    from_col  = fc;
    from_row  = fr;
    to_col    = tc;
    to_row    = tr;
    capture   = cap;
    victim_id = vid;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_ready", 32'(move_ready), 1);
    chk("rst_active", 32'(anim_active), 0);
    chk("rst_offx", 32'(offsetX), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    tick();

    // Horizontal move (0,0)->(1,0), STEP 4
    setup(5'd3, 3'd0, 3'd0, 3'd1, 3'd0, 1'b0, 5'd0);
    chk("a_ready_pre", 32'(move_ready), 1);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    chk("a_active", 32'(anim_active), 1);
    chk("a_ready", 32'(move_ready), 0);
    chk("a_piece", 32'(anim_piece), 3);
    chk("a_offx0", 32'(offsetX), 0);
    for (int i = 1; i <= 15; i++) begin
      frame();
      chk("a_offx", 32'(offsetX), 32'(4 * i));
      chk("a_offy", 32'(offsetY), 0);
      chk("a_done", 32'(done), (i == 15) ? 1 : 0);
    end
    chk("a_cap_pulse", 32'(capture_pulse), 0);
    chk("a_land_active", 32'(anim_active), 1);
    tick();
    chk("a_done_clr", 32'(done), 0);
    chk("a_ready_back", 32'(move_ready), 1);
    chk("a_hold_x", 32'(offsetX), 60);

    // Diagonal capture (2,3)->(5,1), victim 9
    setup(5'd12, 3'd2, 3'd3, 3'd5, 3'd1, 1'b1, 5'd9);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    chk("b_offx0", 32'(offsetX), 120);
    chk("b_offy0", 32'(offsetY), 180);
    for (int i = 1; i <= 45; i++) begin
      frame();
      chk("b_offx", 32'(offsetX), 32'(120 + 4 * i));
      chk("b_offy", 32'(offsetY), (i <= 30) ? 32'(180 - 4 * i) : 60);
      chk("b_done", 32'(done), (i == 45) ? 1 : 0);
      chk("b_cap_pulse", 32'(capture_pulse), (i == 45) ? 1 : 0);
    end
    chk("b_cap_id", 32'(capture_id), 9);
    tick();
    chk("b_cap_clr", 32'(capture_pulse), 0);

    // Asynchronous reset in the middle of a move
    setup(5'd5, 3'd0, 3'd0, 3'd7, 3'd7, 1'b0, 5'd0);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    frame();
    frame();
    frame();
    chk("c_mid_offx", 32'(offsetX), 12);
    reset_n = 1'b0;
    #2;
    chk("c_rst_ready", 32'(move_ready), 1);
    chk("c_rst_active", 32'(anim_active), 0);
    chk("c_rst_offx", 32'(offsetX), 0);
    chk("c_rst_offy", 32'(offsetY), 0);
    chk("c_rst_piece", 32'(anim_piece), 0);
    chk("c_rst_capid", 32'(capture_id), 0);
    chk("c_rst_done", 32'(done), 0);
    reset_n = 1'b1;
    tick();
    chk("c_ready_rel", 32'(move_ready), 1);

    // Cancel coincident with the 5th frame of (3,3)->(3,6)
    setup(5'd7, 3'd3, 3'd3, 3'd3, 3'd6, 1'b0, 5'd0);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    for (int i = 1; i <= 4; i++) frame();
    chk("d_offy4", 32'(offsetY), 196);
    tick();
    cancel      = 1'b1;
    frame_start = 1'b1;
    tick();
    cancel      = 1'b0;
    frame_start = 1'b0;
    chk("d_offy", 32'(offsetY), 180);
    chk("d_offx", 32'(offsetX), 180);
    chk("d_idle", 32'(move_ready), 1);
    chk("d_active", 32'(anim_active), 0);
    chk("d_done", 32'(done), 0);
    tick();
    chk("d_done_later", 32'(done), 0);

    // STEP 7 instance: (0,0)->(1,0), last step clipped to 4
    setup(5'd1, 3'd0, 3'd0, 3'd1, 3'd0, 1'b0, 5'd0);
    move_valid7 = 1'b1;
    tick();
    move_valid7 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      frame();
      chk("e_offx", 32'(offsetX7), (i < 9) ? 32'(7 * i) : 60);
      chk("e_done", 32'(done7), (i == 9) ? 1 : 0);
    end
    chk("e_main_idle", 32'(anim_active), 0);

    // Same-square move accepted together with frame_start
    setup(5'd20, 3'd4, 3'd4, 3'd4, 3'd4, 1'b0, 5'd0);
    tick();
    move_valid  = 1'b1;
    frame_start = 1'b1;
    tick();
    move_valid  = 1'b0;
    frame_start = 1'b0;
    chk("f_active", 32'(anim_active), 1);
    chk("f_done0", 32'(done), 0);
    tick();
    chk("f_done1", 32'(done), 0);
    frame();
    chk("f_done", 32'(done), 1);
    chk("f_offx", 32'(offsetX), 240);
    chk("f_offy", 32'(offsetY), 240);
    tick();
    chk("f_ready", 32'(move_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piece_move_animator.md
# piece_move_animator

Sequences the on-screen slide of one chess piece from a source square to a destination square across successive video frames. It accepts a move command over a valid/ready handshake, steps the piece's board-relative pixel offset toward the target once per frame, and reports landing and capture events. It sits between the game-logic move engine and the per-piece sprite renderers. During an animation it drives the `offsetX`/`offsetY` of the moving piece. At landing it pulses the capture flag for the victim piece.

## Interface
Parameters:
- `SQUARE`, default 60: square edge in pixels; offset = index × `SQUARE`.
- `STEP`, default 4: maximum pixels moved per axis per frame (1..`SQUARE`).

Ports:
- `vga_clk`, in, 1: pixel clock; the only clock in the block.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `frame_start`, in, 1: single-cycle pulse, once per frame, at the start of vertical blank.
- `move_valid`, in, 1: move command valid.
- `move_ready`, out, 1: block can accept a command.
- `piece_id`, in, 5: identifier of the piece to move (0..31).
- `from_col`, `from_row`, in, 3 each: source square.
- `to_col`, `to_row`, in, 3 each: destination square.
- `capture`, in, 1: destination square is occupied by an enemy piece.
- `victim_id`, in, 5: identifier of the captured piece; used only when `capture`=1.
- `cancel`, in, 1: abort the animation in flight.
- `anim_active`, out, 1: an animation is in progress.
- `anim_piece`, out, 5: latched `piece_id`.
- `offsetX`, `offsetY`, out, 10 each: current board-relative offset of `anim_piece`.
- `done`, out, 1: single-cycle pulse when the piece lands.
- `capture_pulse`, out, 1: single-cycle pulse, coincident with `done`, when the latched `capture`=1.
- `capture_id`, out, 5: latched `victim_id`.

## Operation
States: IDLE, MOVE, LAND.

IDLE:
- `move_ready`=1 (decoded from state) and `anim_active`=0.
- On `move_valid`&&`move_ready`:
  - latch `piece_id`, `capture` and `victim_id`;
  - load `curX`=`from_col`·`SQUARE`, `curY`=`from_row`·`SQUARE`;
  - load `tgtX`=`to_col`·`SQUARE`, `tgtY`=`to_row`·`SQUARE`;
  - go to MOVE.

MOVE:
- `anim_active`=1, `move_ready`=0.
- On `frame_start`, each axis updates independently:
  - compute diff = tgt − cur as an 11-bit signed value;
  - cur += sign(diff) × min(`STEP`, |diff|).
- If both updated values equal their targets, go to LAND on the same edge.

LAND:
- Lasts exactly one cycle.
- `done`=1, and `capture_pulse`=latched `capture`.
- `anim_active` stays 1.
- Next state is IDLE.

`cancel` in MOVE:
- cur is restored to the latched source offsets.
- Go directly to IDLE; no `done` and no `capture_pulse`.
- `cancel` has priority over a simultaneous `frame_start`.
- `cancel` is ignored in IDLE and LAND.

Arithmetic and width rules:
- Offsets never exceed 7·`SQUARE`=420 and fit in 10 bits.
- The step never overshoots the target.
- A source square equal to the destination square is legal: no motion occurs, and the block lands at the first `frame_start`.
- Frame count = max(⌈|dx|/`STEP`⌉, ⌈|dy|/`STEP`⌉), with a minimum of 1.

After the animation returns to IDLE:
- `offsetX`/`offsetY` and `anim_piece` hold their last values.
- The game engine is responsible for committing board state on `done`.

## Timing
- Reset values:
  - state IDLE, `move_ready`=1, `anim_active`=0;
  - `anim_piece`=0, `offsetX`=`offsetY`=0;
  - `done`=0, `capture_pulse`=0, `capture_id`=0.
- Accept-to-`anim_active` latency is one cycle: registered outputs update on the edge that samples the handshake.
- `move_valid` coincident with `frame_start` in IDLE: the command is accepted; the first step waits for the next `frame_start`.
- Offsets change only on `frame_start` edges, or on the cancel edge. They are therefore stable for a full frame, and renderers sample them glitch-free.
- `done` is asserted the cycle after the landing `frame_start`.
- `move_ready` returns to 1 the cycle after `done`, so at most one command is in flight.
- `reset_n` low mid-MOVE forces the reset values immediately; no `done` is produced.
- `frame_start` pulses in LAND or IDLE are ignored.

## Test plan
- Reset with `reset_n`=0 during MOVE → all outputs at reset values at once, with no clock edge needed; `move_ready`=1 after release.
- Move (col0,row0)→(col1,row0), `STEP`=4 → `offsetX` goes 0,4,…,60 over 15 `frame_start`s; `offsetY`=0 throughout; `done` one cycle after the 15th pulse.
- Diagonal (2,3)→(5,1) with `capture`=1, `victim_id`=9:
  - X goes 120→300 and Y goes 180→60;
  - Y reaches 60 after 30 frames, X reaches 300 after 45;
  - `done` and `capture_pulse` follow the 45th frame, with `capture_id`=9.
- `STEP`=7, move (0,0)→(1,0) → X sequence 7,14,…,56,60 (9 frames), with no overshoot.
- `cancel` asserted simultaneously with the 5th `frame_start` of a move (3,3)→(3,6) → Y restored to 180, IDLE next cycle, `done` never asserted.
- Same-square move (4,4)→(4,4) accepted together with `frame_start` → no landing on that pulse; `done` after the next `frame_start`; offsets stay (240,240).
